// File: rtl/pattern_misr_pkg.sv
// Shared types, widths and the MISR update function for the pattern response compactor.
package pattern_misr_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned SIG_W  = 16;
  localparam int unsigned CNT_W  = 16;

  localparam logic [SIG_W-1:0] POLY_DEFAULT = 16'h1021;
  localparam logic [SIG_W-1:0] SEED_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One MISR step: shift, polynomial feedback from the MSB, fold in the zero-extended vector.
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0]  sig,
                                                 input logic [DATA_W-1:0] data,
                                                 input logic [SIG_W-1:0]  poly);
    logic [SIG_W-1:0] fb;
    fb = sig[SIG_W-1] ? poly : '0;
    return {sig[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(data);
  endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register: seed load on run launch, one MISR step per accepted vector.
module misr_core
  import pattern_misr_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY = POLY_DEFAULT,
  parameter logic [SIG_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              shift_en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [SIG_W-1:0]  sig_o
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (shift_en_i) begin
      sig_d = misr_next(sig_q, data_i, POLY);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/pattern_response_misr.sv
// Response compactor: accepts a run of response vectors, folds them into a MISR,
// then compares the final signature against the expected value.
module pattern_response_misr
  import pattern_misr_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY = POLY_DEFAULT,
  parameter logic [SIG_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vectors,
  input  logic [SIG_W-1:0]  exp_sig,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  vec_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [SIG_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             start_ok_c;
  logic             xfer_c;
  logic             last_c;
  logic [SIG_W-1:0] sig_c;

  assign start_ok_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign xfer_c     = in_valid && in_ready_q;
  assign last_c     = xfer_c && (cnt_q == (num_q - CNT_W'(1)));

  always_ff @(posedge blif_clk_net) begin
    if (!blif_reset_net) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok_c) begin
          state_d = (num_vectors != '0) ? ST_RUN : ST_CHECK;
        end
      end
      ST_RUN: begin
        if (last_c) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with state_q.
  always_comb begin
    num_d      = num_q;
    exp_d      = exp_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    in_ready_d = (state_d == ST_RUN);
    busy_d     = (state_d == ST_RUN) || (state_d == ST_CHECK);
    done_d     = (state_d == ST_DONE);
    if (start_ok_c) begin
      num_d  = num_vectors;
      exp_d  = exp_sig;
      cnt_d  = '0;
      pass_d = 1'b0;
    end else if (state_q == ST_CHECK) begin
      pass_d = (sig_c == exp_q);
    end else if (xfer_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge blif_clk_net) begin
    if (!blif_reset_net) begin
      num_q      <= '0;
      exp_q      <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      num_q      <= num_d;
      exp_q      <= exp_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  misr_core #(
    .POLY(POLY),
    .SEED(SEED)
  ) u_misr_core (
    .clk_i      (blif_clk_net),
    .rst_ni     (blif_reset_net),
    .load_i     (start_ok_c),
    .shift_en_i (xfer_c),
    .data_i     (in_data),
    .sig_o      (sig_c)
  );

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_c;
  assign vec_count = cnt_q;

endmodule

// File: tb/tb_pattern_response_misr.sv
// Directed bench for pattern_response_misr with hand-computed MISR signatures.
module tb_pattern_response_misr;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vectors;
  logic [15:0] exp_sig;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] vec_count;

  int total;
  int bad;

  pattern_response_misr dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_n),
    .start          (start),
    .num_vectors    (num_vectors),
    .exp_sig        (exp_sig),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .signature      (signature),
    .vec_count      (vec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"},  32'(busy),     32'd0);
    chk({tag, "_done"},  32'(done),     32'd0);
    chk({tag, "_pass"},  32'(pass),     32'd0);
    chk({tag, "_sig"},   32'(signature), 32'd0);
    chk({tag, "_cnt"},   32'(vec_count), 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    num_vectors = '0;
    exp_sig = '0;
    in_valid = 1'b0;
    in_data = '0;
    step();
    step();
    rst_n = 1'b1;
    chk_idle_zero("reset");

    // Single vector 000: FFFF -> EFDF
    start = 1'b1; num_vectors = 16'd1; exp_sig = 16'hEFDF;
    step();
    start = 1'b0;
    chk("one_ready", 32'(in_ready), 32'd1);
    chk("one_busy", 32'(busy), 32'd1);
    chk("one_seed", 32'(signature), 32'hFFFF);
    in_valid = 1'b1; in_data = 12'h000;
    step();
    in_valid = 1'b0;
    chk("one_sig", 32'(signature), 32'hEFDF);
    chk("one_cnt", 32'(vec_count), 32'd1);
    chk("one_ready_drop", 32'(in_ready), 32'd0);
    chk("one_not_done_yet", 32'(done), 32'd0);
    step();
    chk("one_done", 32'(done), 32'd1);
    chk("one_pass", 32'(pass), 32'd1);
    chk("one_busy_off", 32'(busy), 32'd0);

    // in_valid in DONE is ignored
    in_valid = 1'b1; in_data = 12'h123;
    step();
    in_valid = 1'b0;
    chk("done_guard_sig", 32'(signature), 32'hEFDF);
    chk("done_guard_cnt", 32'(vec_count), 32'd1);
    chk("done_hold", 32'(done), 32'd1);

    // Two vectors back to back, launched from DONE
    start = 1'b1; num_vectors = 16'd2; exp_sig = 16'hCF9E;
    step();
    start = 1'b0;
    chk("two_restart_sig", 32'(signature), 32'hFFFF);
    chk("two_restart_cnt", 32'(vec_count), 32'd0);
    chk("two_restart_done", 32'(done), 32'd0);
    chk("two_restart_pass", 32'(pass), 32'd0);
    in_valid = 1'b1; in_data = 12'h000;
    step();
    chk("two_sig1", 32'(signature), 32'hEFDF);
    in_data = 12'h001;
    step();
    in_valid = 1'b0;
    chk("two_sig2", 32'(signature), 32'hCF9E);
    chk("two_cnt", 32'(vec_count), 32'd2);
    step();
    chk("two_done", 32'(done), 32'd1);
    chk("two_pass", 32'(pass), 32'd1);

    // Same data, wrong expected signature
    start = 1'b1; num_vectors = 16'd2; exp_sig = 16'hCF9F;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 12'h000;
    step();
    in_data = 12'h001;
    step();
    in_valid = 1'b0;
    step();
    chk("bad_done", 32'(done), 32'd1);
    chk("bad_pass", 32'(pass), 32'd0);
    chk("bad_sig", 32'(signature), 32'hCF9E);

    // Empty run
    start = 1'b1; num_vectors = 16'd0; exp_sig = 16'hFFFF;
    step();
    start = 1'b0;
    chk("empty_ready", 32'(in_ready), 32'd0);
    chk("empty_busy", 32'(busy), 32'd1);
    chk("empty_not_done", 32'(done), 32'd0);
    step();
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_pass", 32'(pass), 32'd1);
    chk("empty_sig", 32'(signature), 32'hFFFF);
    chk("empty_cnt", 32'(vec_count), 32'd0);

    // Bubbles 1,0,0,1 with a stray start during RUN
    start = 1'b1; num_vectors = 16'd2; exp_sig = 16'hCF9E;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 12'h000;
    step();
    in_valid = 1'b0; in_data = 12'hABC;
    start = 1'b1; num_vectors = 16'd5; exp_sig = 16'h0000;
    step();
    start = 1'b0;
    chk("bub_start_ign_cnt", 32'(vec_count), 32'd1);
    chk("bub_start_ign_sig", 32'(signature), 32'hEFDF);
    step();
    chk("bub_hold_cnt", 32'(vec_count), 32'd1);
    chk("bub_hold_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 12'h001;
    step();
    in_valid = 1'b0;
    chk("bub_sig", 32'(signature), 32'hCF9E);
    chk("bub_cnt", 32'(vec_count), 32'd2);
    chk("bub_ready_drop", 32'(in_ready), 32'd0);
    step();
    chk("bub_done", 32'(done), 32'd1);
    chk("bub_pass", 32'(pass), 32'd1);

    // Reset mid-run after 1 of 3 vectors
    start = 1'b1; num_vectors = 16'd3; exp_sig = 16'h0000;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 12'h005;
    step();
    in_valid = 1'b0;
    chk("mid_cnt", 32'(vec_count), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_idle_zero("midrst");
    step();
    chk("midrst_no_done", 32'(done), 32'd0);

    start = 1'b1; num_vectors = 16'd1; exp_sig = 16'hEFDF;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 12'h000;
    step();
    in_valid = 1'b0;
    step();
    chk("post_rst_sig", 32'(signature), 32'hEFDF);
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_pass", 32'(pass), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_response_misr.md
Name: pattern_response_misr

Overview:
- Response compactor for the merged-pattern test circuits; the receive end of the stimulus/response path.
- Consumes the 12-bit output vector of a merged pattern netlist over a valid/ready stream.
- Folds each vector into a multiple-input signature register (MISR), counts accepted vectors, and compares the final signature against an expected value.
- Sits between the device-under-test outputs and the bench/scan controller, which launches a run and reads pass/fail.

Parameters:
- DATA_W, 12, width of one response vector from the circuit under test
- SIG_W, 16, MISR width; must satisfy SIG_W >= DATA_W
- POLY, 16'h1021, MISR feedback polynomial mask (bit i set = tap into bit i)
- SEED, 16'hFFFF, signature value loaded at start of run
- CNT_W, 16, width of vector count and run length

Ports:
- blif_clk_net  input  1  single clock, rising edge
- blif_reset_net  input  1  reset, synchronous, active-low
- start  input  1  one-cycle run launch; honoured only in IDLE or DONE
- num_vectors  input  CNT_W  vectors in the run; sampled on accepted start
- exp_sig  input  SIG_W  expected signature; sampled on accepted start
- in_valid  input  1  response vector valid
- in_ready  output  1  block accepts a vector this cycle
- in_data  input  DATA_W  response vector
- busy  output  1  run in progress (RUN or CHECK)
- done  output  1  high while in DONE
- pass  output  1  final signature == exp_sig; valid while done=1
- signature  output  SIG_W  current MISR contents
- vec_count  output  CNT_W  vectors accepted this run

Behaviour:
- Reset: blif_reset_net=0 sampled at a rising edge forces state=IDLE.
  - All outputs are 0: in_ready, busy, done, pass, signature, vec_count.
  - Latched num_vectors and exp_sig are cleared.
  - Reset mid-run discards the run; no partial done is produced.
- States and transitions:
  - IDLE, start=1, num_vectors!=0 → RUN. Latch num_vectors and exp_sig; signature<=SEED; vec_count<=0.
  - IDLE, start=1, num_vectors==0 → CHECK. signature<=SEED; empty run.
  - RUN: in_ready=1, registered, asserted the cycle after entry. A transfer occurs when in_valid && in_ready.
    - Each transfer: signature <= (signature<<1) ^ (signature[SIG_W-1] ? POLY : 0) ^ zero_extend(in_data); vec_count++.
    - The transfer where vec_count == num_vectors-1 → CHECK; in_ready drops the next cycle.
    - in_valid=0 → hold; there is no timeout.
  - CHECK: one cycle. Registers pass <= (signature == exp_sig) → DONE.
  - DONE: done=1; pass, signature and vec_count are held.
    - start=1 launches a new run exactly as from IDLE.
    - There is no return to IDLE except by reset.
- start in RUN or CHECK is ignored. in_valid outside RUN is ignored; in_data is not sampled.
- Latency: last accepted transfer at cycle T → done=1 at T+2. Empty run: start at T → done=1 at T+2.
- Throughput: one vector per cycle while in_valid is held high.
- vec_count is not allowed to wrap, because num_vectors <= 2^CNT_W-1 by width.
- busy = (state==RUN || state==CHECK).
- pass is 0 whenever done=0.

Decomposition:
- Package pattern_misr_pkg holds:
  - state enum {IDLE, RUN, CHECK, DONE}
  - default POLY and SEED constants
  - a misr_next function (sig, data → next sig)
- One sub-module, misr_core, holds the signature register and its update/load logic (load, shift_en, data). The FSM and counter stay in the top.

Test Plan:
- Single vector: start, num_vectors=1, exp_sig=16'hEFDF, in_data=12'h000 → signature=16'hEFDF, vec_count=1, done=1 two cycles after the transfer, pass=1.
- Two vectors, 12'h000 then 12'h001, exp_sig=16'hCF9E → signature after first vector EFDF, final CF9E, pass=1. Rerun with exp_sig=16'hCF9F → pass=0.
- Empty run: start, num_vectors=0, exp_sig=16'hFFFF → no in_ready pulse; done=1 at start+2, signature=FFFF, pass=1.
- Backpressure and bubbles: num_vectors=2 with in_valid toggled 1,0,0,1 → exactly 2 transfers, same signature as the back-to-back case, in_ready=0 after the second transfer.
- Protocol guards:
  - start asserted during RUN → no effect on count or signature.
  - in_valid=1 in IDLE/DONE → signature unchanged.
  - start in DONE → new run with signature=FFFF, vec_count=0.
- Reset mid-run: blif_reset_net=0 for one edge after 1 of 3 vectors → IDLE next cycle with all outputs 0. A following start/num_vectors=1/in_data=000 still gives EFDF.
